// File: rtl/pair_funnel_accumulator.sv
// Funnel-shifts two retrieved word pairs and XOR-accumulates them into a flop bank,
// with constant-time dummy requests and a handshaked drain stream.
module pair_funnel_accumulator #(
   parameter int WORD_WIDTH = 32,
   parameter int ACC_SIZE   = 19,
   parameter int IDX_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] high_right_word,
   input  logic [WORD_WIDTH-1:0] high_left_word,
   input  logic [WORD_WIDTH-1:0] low_right_word,
   input  logic [WORD_WIDTH-1:0] low_left_word,
   input  logic [4:0]            shift_amt,
   input  logic [IDX_WIDTH-1:0]  dest_idx,
   input  logic                  in_dummy,
   input  logic                  clear,
   input  logic                  drain_req,
   output logic [WORD_WIDTH-1:0] out_word,
   output logic [IDX_WIDTH-1:0]  out_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  idx_err
);

   typedef enum logic [1:0] {ST_ACCUM, ST_CLEAR, ST_DRAIN} state_t;

   localparam logic [IDX_WIDTH-1:0] ACC_LAST = IDX_WIDTH'(ACC_SIZE - 1);

   function automatic logic [WORD_WIDTH-1:0] funnel(input logic [WORD_WIDTH-1:0] l,
                                                    input logic [WORD_WIDTH-1:0] r,
                                                    input logic [4:0]            s);
      logic [2*WORD_WIDTH-1:0] cat;
      cat = {l, r} >> s;
      return cat[WORD_WIDTH-1:0];
   endfunction

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  k_q, k_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [WORD_WIDTH-1:0] hi_q, hi_d;
   logic [WORD_WIDTH-1:0] lo_q, lo_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic                  dummy_q, dummy_d;
   logic                  bad_q, bad_d;
   logic                  idx_err_q, idx_err_d;
   logic [WORD_WIDTH-1:0] acc_q [ACC_SIZE];
   logic [WORD_WIDTH-1:0] acc_d [ACC_SIZE];

   logic                  accept;
   logic                  wr;
   logic                  range_bad;
   logic [IDX_WIDTH-1:0]  idx_next;

   assign in_ready  = (state_q == ST_ACCUM) && !clear && !drain_req;
   assign accept    = in_valid && in_ready;
   assign range_bad = dest_idx > ACC_LAST;
   assign wr        = s1_valid_q && !dummy_q;
   assign idx_next  = (idx_q == ACC_LAST) ? '0 : idx_q + 1'b1;

   assign out_valid = (state_q == ST_DRAIN);
   assign out_idx   = out_valid ? k_q : '0;
   assign out_word  = out_valid ? acc_q[k_q] : '0;
   assign out_last  = out_valid && (k_q == ACC_LAST);
   assign busy      = s1_valid_q || (state_q != ST_ACCUM);
   assign idx_err   = idx_err_q;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      s1_valid_d = accept;
      hi_d       = hi_q;
      lo_d       = lo_q;
      idx_d      = idx_q;
      dummy_d    = dummy_q;
      bad_d      = bad_q;
      idx_err_d  = idx_err_q || (s1_valid_q && bad_q);

      if (accept) begin
         hi_d    = funnel(high_left_word, high_right_word, shift_amt);
         lo_d    = funnel(low_left_word, low_right_word, shift_amt);
         idx_d   = dest_idx;
         dummy_d = in_dummy || range_bad;
         bad_d   = range_bad;
      end

      // When d is the last index both halves may land on distinct words; with one word they fold together.
      for (int i = 0; i < ACC_SIZE; i++) begin
         acc_d[i] = acc_q[i]
                  ^ ((wr && idx_q    == IDX_WIDTH'(i)) ? hi_q : '0)
                  ^ ((wr && idx_next == IDX_WIDTH'(i)) ? lo_q : '0);
      end

      case (state_q)
         ST_ACCUM: begin
            if (clear) begin
               state_d = ST_CLEAR;
            end else if (drain_req && !s1_valid_q) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end
         end
         ST_CLEAR: begin
            for (int i = 0; i < ACC_SIZE; i++) begin
               acc_d[i] = '0;
            end
            idx_err_d  = 1'b0;
            s1_valid_d = 1'b0;
            state_d    = ST_ACCUM;
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (k_q == ACC_LAST) begin
                  k_d     = '0;
                  state_d = ST_ACCUM;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ACCUM;
         k_q        <= '0;
         s1_valid_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         idx_q      <= '0;
         dummy_q    <= 1'b0;
         bad_q      <= 1'b0;
         idx_err_q  <= 1'b0;
         for (int i = 0; i < ACC_SIZE; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         s1_valid_q <= s1_valid_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         idx_q      <= idx_d;
         dummy_q    <= dummy_d;
         bad_q      <= bad_d;
         idx_err_q  <= idx_err_d;
         for (int i = 0; i < ACC_SIZE; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pair_funnel_accumulator.sv
// Scoreboard bench for pair_funnel_accumulator: directed requests with hand-computed
// accumulator contents, drained words checked by an independent monitor.
module tb_pair_funnel_accumulator;

   localparam int W = 32;
   localparam int N = 19;
   localparam int IW = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  high_right_word, high_left_word, low_right_word, low_left_word;
   logic [4:0]    shift_amt;
   logic [IW-1:0] dest_idx;
   logic          in_dummy, clear, drain_req;
   logic [W-1:0]  out_word;
   logic [IW-1:0] out_idx;
   logic          out_valid, out_ready, out_last, busy, idx_err;

   typedef struct {
      logic [IW-1:0] idx;
      logic [W-1:0]  word;
      logic          last;
   } beat_t;

   beat_t        sbq[$];
   logic [W-1:0] exp_acc [N];
   int           checks = 0;
   int           errors = 0;
   int           beats  = 0;

   pair_funnel_accumulator #(.WORD_WIDTH(W), .ACC_SIZE(N), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .high_right_word(high_right_word), .high_left_word(high_left_word),
      .low_right_word(low_right_word), .low_left_word(low_left_word),
      .shift_amt(shift_amt), .dest_idx(dest_idx), .in_dummy(in_dummy),
      .clear(clear), .drain_req(drain_req), .out_word(out_word), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .idx_err(idx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drives one request; it is taken on the next rising edge if in_ready is high.
   task automatic applyStimulus(input logic [W-1:0] hl, input logic [W-1:0] hr,
                                input logic [W-1:0] ll, input logic [W-1:0] lr,
                                input logic [4:0] sh, input logic [IW-1:0] dst, input logic dmy);
      in_valid        = 1'b1;
      high_left_word  = hl;
      high_right_word = hr;
      low_left_word   = ll;
      low_right_word  = lr;
      shift_amt       = sh;
      dest_idx        = dst;
      in_dummy        = dmy;
      @(posedge clk) #1;
   endtask

   task automatic idleCycle();
      in_valid = 1'b0;
      @(posedge clk) #1;
   endtask

   task automatic pushDrain();
      beat_t b;
      for (int k = 0; k < N; k++) begin
         b.idx  = IW'(k);
         b.word = exp_acc[k];
         b.last = (k == N - 1);
         sbq.push_back(b);
      end
   endtask

   task automatic doDrain(input bit toggle);
      int cyc;
      in_valid  = 1'b0;
      beats     = 0;
      pushDrain();
      drain_req = 1'b1;
      out_ready = toggle ? 1'b0 : 1'b1;
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(posedge clk) #1;
         cyc++;
      end
      drain_req = 1'b0;
      while (busy && cyc < 200) begin
         if (toggle) out_ready = ~out_ready;
         @(posedge clk) #1;
         cyc++;
      end
      out_ready = 1'b1;
      checkOutput("drain_done", {31'b0, busy}, 32'd0);
      checkOutput("drain_beats", beats, N);
      checkOutput("sb_empty", sbq.size(), 0);
      sbq.delete();
   endtask

   // Monitor: every presented beat is compared to the queue head, including stalled cycles.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat actual idx=%0d expected none", out_idx);
         end else begin
            checkOutput("beat_idx", {27'b0, out_idx}, {27'b0, sbq[0].idx});
            checkOutput("beat_word", out_word, sbq[0].word);
            checkOutput("beat_last", {31'b0, out_last}, {31'b0, sbq[0].last});
            checkOutput("drain_in_ready", {31'b0, in_ready}, 32'd0);
            if (out_ready) begin
               void'(sbq.pop_front());
               beats++;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_dummy = 1'b0; clear = 1'b0; drain_req = 1'b0; out_ready = 1'b1;
      high_left_word = '0; high_right_word = '0; low_left_word = '0; low_right_word = '0;
      shift_amt = '0; dest_idx = '0;
      for (int i = 0; i < N; i++) exp_acc[i] = '0;
      #12;
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out_word", out_word, 32'd0);
      checkOutput("rst_out_idx", {27'b0, out_idx}, 32'd0);
      checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_idx_err", {31'b0, idx_err}, 32'd0);
      @(posedge clk) #1;
      rst_n = 1'b1;
      @(posedge clk) #1;

      $display("[TB] test 1: basic funnel");
      applyStimulus(32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 32'h0, 5'd8, 5'd3, 1'b0);
      checkOutput("t1_busy", {31'b0, busy}, 32'd1);
      exp_acc[3] = 32'hEFCAFEBA;
      doDrain(1'b0);

      $display("[TB] test 2/3: wrap, shift 0, back-to-back xor");
      applyStimulus(32'h0, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd18, 1'b0);
      applyStimulus(32'h0, 32'h0, 32'hBEEFDEAD, 32'hDEADBEEF, 5'd16, 5'd18, 1'b0);
      applyStimulus(32'h0, 32'hAAAAAAAA, 32'h0, 32'h0, 5'd0, 5'd5, 1'b0);
      applyStimulus(32'h0, 32'h55555555, 32'h0, 32'h0, 5'd0, 5'd5, 1'b0);
      idleCycle();
      exp_acc[18] = 32'h12345678;
      exp_acc[0]  = 32'hDEADDEAD;
      exp_acc[5]  = 32'hFFFFFFFF;
      doDrain(1'b0);

      $display("[TB] test 4: dummy and range check");
      applyStimulus(32'h0, 32'h11111111, 32'h0, 32'h77777777, 5'd0, 5'd7, 1'b1);
      checkOutput("t4_dummy_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("t4_dummy_busy", {31'b0, busy}, 32'd1);
      idleCycle();
      checkOutput("t4_dummy_idx_err", {31'b0, idx_err}, 32'd0);
      applyStimulus(32'h0, 32'h22222222, 32'h0, 32'h33333333, 5'd0, 5'd25, 1'b0);
      checkOutput("t4_range_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("t4_range_idx_err_early", {31'b0, idx_err}, 32'd0);
      idleCycle();
      checkOutput("t4_range_idx_err", {31'b0, idx_err}, 32'd1);
      checkOutput("t4_busy_idle", {31'b0, busy}, 32'd0);

      $display("[TB] test 5: drain backpressure");
      doDrain(1'b1);
      checkOutput("t5_idx_err_kept", {31'b0, idx_err}, 32'd1);

      $display("[TB] test 6: clear and reset");
      clear = 1'b1;
      #1;
      checkOutput("t6_clear_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk) #1;
      clear = 1'b0;
      checkOutput("t6_clear_busy", {31'b0, busy}, 32'd1);
      @(posedge clk) #1;
      checkOutput("t6_clear_idx_err", {31'b0, idx_err}, 32'd0);
      checkOutput("t6_clear_done", {31'b0, busy}, 32'd0);
      for (int i = 0; i < N; i++) exp_acc[i] = '0;
      doDrain(1'b0);

      applyStimulus(32'h0, 32'h0F0F0F0F, 32'h0, 32'h0, 5'd0, 5'd2, 1'b0);
      idleCycle();
      exp_acc[2] = 32'h0F0F0F0F;
      beats = 0;
      pushDrain();
      drain_req = 1'b1;
      out_ready = 1'b1;
      @(posedge clk) #1;
      drain_req = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("t6_rst_out_idx", {27'b0, out_idx}, 32'd0);
      checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("t6_rst_beats", beats, 4);
      sbq.delete();
      @(posedge clk) #1;
      rst_n = 1'b1;
      @(posedge clk) #1;
      for (int i = 0; i < N; i++) exp_acc[i] = '0;
      doDrain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
